// File: rtl/twin_word_deserializer_if.sv
// Serial input / parallel pair output bundle for the twin word deserializer.
// The master drives the serial stream; the slave (the deserializer) returns the word pair.
interface twin_word_deserializer_if #(
    parameter int WIDTH = 8
) ();
    logic             sin;
    logic             sin_valid;
    logic             frame_start;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic             pair_valid;
    logic             frame_err;
    logic             busy;

    modport master (
        output sin,
        output sin_valid,
        output frame_start,
        input  d1,
        input  d2,
        input  pair_valid,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  sin,
        input  sin_valid,
        input  frame_start,
        output d1,
        output d2,
        output pair_valid,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/twin_word_deserializer.sv
// Collects a framed serial bit stream into two WIDTH-bit words (A then B) and presents them
// as a registered pair with a one-cycle strobe; a frame_start seen mid-frame restarts the frame.
module twin_word_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    twin_word_deserializer_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SHIFT_A = 2'd1;
    localparam logic [1:0] SHIFT_B = 2'd2;

    logic [1:0]       state_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] sr_r;
    logic [WIDTH-1:0] hold_a_r;
    logic [WIDTH-1:0] d1_r;
    logic [WIDTH-1:0] d2_r;
    logic             pair_valid_r;
    logic             frame_err_r;
    logic             busy_r;

    logic [1:0]       state_n_s;
    logic [CW-1:0]    cnt_n_s;
    logic [WIDTH-1:0] sr_n_s;
    logic [WIDTH-1:0] hold_n_s;
    logic [WIDTH-1:0] d1_n_s;
    logic [WIDTH-1:0] d2_n_s;
    logic             pair_valid_n_s;
    logic             frame_err_n_s;

    logic [WIDTH-1:0] sr_shift_s;
    logic [WIDTH-1:0] sr_first_s;
    logic             last_s;

    // The first bit of a frame starts from a clean register so no stale bits survive a resync.
    assign sr_shift_s = MSB_FIRST ? {sr_r[WIDTH-2:0], bus.sin} : {bus.sin, sr_r[WIDTH-1:1]};
    assign sr_first_s = MSB_FIRST ? {{(WIDTH-1){1'b0}}, bus.sin} : {bus.sin, {(WIDTH-1){1'b0}}};
    assign last_s     = (cnt_r == CW'(WIDTH - 1));

    // Next-state logic: only accepted bits (sin_valid high) move the FSM.
    always_comb begin
        state_n_s      = state_r;
        cnt_n_s        = cnt_r;
        sr_n_s         = sr_r;
        hold_n_s       = hold_a_r;
        d1_n_s         = d1_r;
        d2_n_s         = d2_r;
        pair_valid_n_s = 1'b0;
        frame_err_n_s  = 1'b0;
        if (bus.sin_valid && bus.frame_start) begin
            // A frame start outside IDLE is a resync, including on the final bit of B.
            frame_err_n_s = (state_r != IDLE);
            state_n_s     = SHIFT_A;
            cnt_n_s       = CW'(1);
            sr_n_s        = sr_first_s;
        end else if (bus.sin_valid) begin
            case (state_r)
                IDLE: begin
                    state_n_s = IDLE;
                end
                SHIFT_A: begin
                    sr_n_s = sr_shift_s;
                    if (last_s) begin
                        hold_n_s  = sr_shift_s;
                        cnt_n_s   = {CW{1'b0}};
                        state_n_s = SHIFT_B;
                    end else begin
                        cnt_n_s = cnt_r + CW'(1);
                    end
                end
                SHIFT_B: begin
                    sr_n_s = sr_shift_s;
                    if (last_s) begin
                        d1_n_s         = hold_a_r;
                        d2_n_s         = sr_shift_s;
                        pair_valid_n_s = 1'b1;
                        cnt_n_s        = {CW{1'b0}};
                        state_n_s      = IDLE;
                    end else begin
                        cnt_n_s = cnt_r + CW'(1);
                    end
                end
                default: begin
                    state_n_s = IDLE;
                    cnt_n_s   = {CW{1'b0}};
                end
            endcase
        end else begin
            state_n_s = state_r;
        end
    end

    // State, datapath and output registers with synchronous reset priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            cnt_r        <= {CW{1'b0}};
            sr_r         <= {WIDTH{1'b0}};
            hold_a_r     <= {WIDTH{1'b0}};
            d1_r         <= {WIDTH{1'b0}};
            d2_r         <= {WIDTH{1'b0}};
            pair_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_n_s;
            cnt_r        <= cnt_n_s;
            sr_r         <= sr_n_s;
            hold_a_r     <= hold_n_s;
            d1_r         <= d1_n_s;
            d2_r         <= d2_n_s;
            pair_valid_r <= pair_valid_n_s;
            frame_err_r  <= frame_err_n_s;
            busy_r       <= (state_n_s != IDLE);
        end
    end

    assign bus.d1         = d1_r;
    assign bus.d2         = d2_r;
    assign bus.pair_valid = pair_valid_r;
    assign bus.frame_err  = frame_err_r;
    assign bus.busy       = busy_r;
endmodule

// File: tb/tb_twin_word_deserializer.sv
// Directed bench for twin_word_deserializer: one MSB-first and one LSB-first instance
// receive the same serial stream and are checked against hand-computed pairs.
module tb_twin_word_deserializer;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    twin_word_deserializer_if #(.WIDTH(W)) bm ();
    twin_word_deserializer_if #(.WIDTH(W)) bl ();

    twin_word_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk (clk),
        .rst (rst),
        .bus (bm.slave)
    );

    twin_word_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk (clk),
        .rst (rst),
        .bus (bl.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle of stimulus to both instances; returns 1ns after the rising edge.
    task automatic drive(input logic v, input logic b, input logic fs);
        @(negedge clk);
        bm.sin = b; bm.sin_valid = v; bm.frame_start = fs;
        bl.sin = b; bl.sin_valid = v; bl.frame_start = fs;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic fs);
        drive(1'b1, b, fs);
    endtask

    task automatic send_word(input logic [7:0] w, input logic fs_first);
        for (int i = W - 1; i >= 0; i--) send_bit(w[i], fs_first && (i == W - 1));
    endtask

    initial begin
        logic [7:0]  wb;
        logic [15:0] stream;

        bm.sin = 1'b0; bm.sin_valid = 1'b0; bm.frame_start = 1'b0;
        bl.sin = 1'b0; bl.sin_valid = 1'b0; bl.frame_start = 1'b0;

        // Reset state
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        check("rst_d1", bm.d1, 32'h00);
        check("rst_d2", bm.d2, 32'h00);
        check("rst_pv", bm.pair_valid, 32'h0);
        check("rst_fe", bm.frame_err, 32'h0);
        check("rst_busy", bm.busy, 32'h0);
        check("rst_lsb_d1", bl.d1, 32'h00);
        rst = 1'b0;

        // Contiguous pair A5/3C; the same bits give A5/3C for the LSB-first instance too
        send_word(8'hA5, 1'b1);
        check("a_done_busy", bm.busy, 32'h1);
        check("a_done_pv", bm.pair_valid, 32'h0);
        wb = 8'h3C;
        for (int i = W - 1; i >= 1; i--) send_bit(wb[i], 1'b0);
        check("bit15_pv", bm.pair_valid, 32'h0);
        send_bit(wb[0], 1'b0);
        check("pair1_d1", bm.d1, 32'hA5);
        check("pair1_d2", bm.d2, 32'h3C);
        check("pair1_pv", bm.pair_valid, 32'h1);
        check("pair1_busy", bm.busy, 32'h0);
        check("pair1_lsb_d1", bl.d1, 32'hA5);
        check("pair1_lsb_d2", bl.d2, 32'h3C);

        // Back-to-back frame, then resync at B bit 5
        send_bit(1'b1, 1'b1);
        check("b2b_pv_drop", bm.pair_valid, 32'h0);
        check("b2b_busy", bm.busy, 32'h1);
        for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b1);
        check("resync_fe", bm.frame_err, 32'h1);
        check("resync_pv", bm.pair_valid, 32'h0);
        check("resync_d1", bm.d1, 32'hA5);
        check("resync_d2", bm.d2, 32'h3C);
        check("resync_busy", bm.busy, 32'h1);
        wb = 8'h01;
        send_bit(wb[6], 1'b0);
        check("resync_fe_drop", bm.frame_err, 32'h0);
        for (int i = 5; i >= 0; i--) send_bit(wb[i], 1'b0);
        send_word(8'h80, 1'b0);
        check("pair2_d1", bm.d1, 32'h01);
        check("pair2_d2", bm.d2, 32'h80);
        check("pair2_pv", bm.pair_valid, 32'h1);
        check("pair2_lsb_d1", bl.d1, 32'h80);
        check("pair2_lsb_d2", bl.d2, 32'h01);

        // frame_start on the final bit of B is a resync, not a completion
        send_word(8'h12, 1'b1);
        for (int i = 0; i < 7; i++) send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b1);
        check("lastbit_fe", bm.frame_err, 32'h1);
        check("lastbit_pv", bm.pair_valid, 32'h0);
        check("lastbit_d1", bm.d1, 32'h01);
        check("lastbit_d2", bm.d2, 32'h80);

        // That resync bit was accepted bit 1; reset lands on accepted bit 10
        for (int i = 0; i < 8; i++) send_bit(1'b1, 1'b0);
        rst = 1'b1;
        send_bit(1'b1, 1'b0);
        rst = 1'b0;
        check("midrst_d1", bm.d1, 32'h00);
        check("midrst_d2", bm.d2, 32'h00);
        check("midrst_pv", bm.pair_valid, 32'h0);
        check("midrst_fe", bm.frame_err, 32'h0);
        check("midrst_busy", bm.busy, 32'h0);
        for (int i = 0; i < 2 * W; i++) begin
            send_bit(1'b1, 1'b0);
            check("idle_bits_pv", bm.pair_valid, 32'h0);
        end
        check("idle_bits_busy", bm.busy, 32'h0);
        check("idle_bits_d1", bm.d1, 32'h00);

        // Same A5/3C stream with gaps; frame_start during gaps must be ignored
        stream = 16'hA53C;
        for (int i = 15; i >= 0; i--) begin
            send_bit(stream[i], i == 15);
            if (i > 0) begin
                check("gap_pv_early", bm.pair_valid, 32'h0);
                repeat ($urandom_range(1, 3)) drive(1'b0, 1'b0, 1'b1);
                check("gap_fe", bm.frame_err, 32'h0);
            end
        end
        check("gap_d1", bm.d1, 32'hA5);
        check("gap_d2", bm.d2, 32'h3C);
        check("gap_pv", bm.pair_valid, 32'h1);
        check("gap_lsb_d1", bl.d1, 32'hA5);
        check("gap_lsb_d2", bl.d2, 32'h3C);
        drive(1'b0, 1'b0, 1'b0);
        check("gap_pv_drop", bm.pair_valid, 32'h0);
        check("gap_hold_d1", bm.d1, 32'hA5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
